// File: rtl/rr_grant_encoder_pkg.sv
// Shared definitions for the round-robin grant encoder.
//   state_t : arbiter FSM encoding (IDLE, GRANT, GAP)
//   N       : number of requesters (matches the 3-to-8 decoder width)
//   IDXW    : width of a requester index, log2(N)
package rr_grant_encoder_pkg;

    localparam int N    = 8;
    localparam int IDXW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_grant_encoder_pick.sv
// Combinational rotating priority encoder.
// Searches R starting at ptr and wrapping modulo N. It returns the first
// requesting index.
//   R   : request vector, R[i] requests index i
//   ptr : index with the highest priority for this search
//   idx : first requesting index at or after ptr (0 when none)
//   any : at least one request is set
module rr_pick
    import rr_grant_encoder_pkg::*;
(
    input  logic [0:N-1]     R,
    input  logic [IDXW-1:0]  ptr,
    output logic [IDXW-1:0]  idx,
    output logic             any
);

    logic [IDXW-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            // Index arithmetic is IDXW bits wide, so ptr+i wraps 7 -> 0.
            cand = ptr + IDXW'(i);
            if (!any && R[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter that drives a 3-to-8 enable decoder.
// It grants one of the 8 requesters at a time. A grant ends when the
// holder asserts Done, when the holder withdraws its request, or when
// the grant has been held for MAX_HOLD cycles. A one-cycle GAP separates
// successive grants. All outputs come from registers.
//
// Handshake: a requester holds R[i] high until it sees En=1 with W=i. It
// keeps R[i] high for as long as it uses the grant. It ends the grant by
// pulsing Done, or by dropping R[i]. Done is sampled only in GRANT.
//
//   Clock     : rising-edge clock
//   Resetn    : synchronous active-low reset
//   R[0:N-1]  : request vector
//   Done      : holder releases the grant
//   W         : encoded index of the current or last grantee (decoder W)
//   En        : grant valid (decoder En)
//   Busy      : high in GRANT and GAP
//   Timeout   : one-cycle pulse after a forced release
//   dbg_state : current FSM state, for observation
module rr_grant_encoder
    import rr_grant_encoder_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNTW     = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [0:N-1]     R,
    input  logic             Done,
    output logic [IDXW-1:0]  W,
    output logic             En,
    output logic             Busy,
    output logic             Timeout,
    output state_t           dbg_state
);

    state_t           state, state_n;
    logic [IDXW-1:0]  ptr, ptr_n;
    logic [CNTW-1:0]  cnt, cnt_n;
    logic [IDXW-1:0]  w_n;
    logic             en_n, busy_n, timeout_n;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_any;

    rr_pick u_pick (
        .R   (R),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            W       <= '0;
            En      <= 1'b0;
            Busy    <= 1'b0;
            Timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            W       <= w_n;
            En      <= en_n;
            Busy    <= busy_n;
            Timeout <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        w_n       = W;
        timeout_n = 1'b0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = GRANT;
                    w_n     = pick_idx;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                // A normal release has priority over the hold limit. If Done
                // arrives on the last allowed cycle, Timeout stays low.
                if (Done || !R[W]) begin
                    state_n = GAP;
                    ptr_n   = W + IDXW'(1);
                end else if (cnt == CNTW'(MAX_HOLD - 1)) begin
                    state_n   = GAP;
                    ptr_n     = W + IDXW'(1);
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // W is not changed outside IDLE->GRANT, so it keeps the last
        // grantee while En is low.
        en_n   = (state_n == GRANT);
        busy_n = (state_n == GRANT) || (state_n == GAP);
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed testbench for rr_grant_encoder, built with MAX_HOLD=4.
// Inputs change 1ns after a rising edge. Outputs are checked at that same
// point, after the edge has updated them.
module tb_rr_grant_encoder;
    import rr_grant_encoder_pkg::*;

    logic             Clock;
    logic             Resetn;
    logic [0:N-1]     R;
    logic             Done;
    logic [IDXW-1:0]  W;
    logic             En;
    logic             Busy;
    logic             Timeout;
    state_t           dbg_state;

    int checks   = 0;
    int failures = 0;

    rr_grant_encoder #(.MAX_HOLD(4), .CNTW(8)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .R         (R),
        .Done      (Done),
        .W         (W),
        .En        (En),
        .Busy      (Busy),
        .Timeout   (Timeout),
        .dbg_state (dbg_state)
    );

    // clock
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input int w, input int en, input int busy, input int tmo);
        check({tag, ".W"},       32'(W),       32'(w));
        check({tag, ".En"},      32'(En),      32'(en));
        check({tag, ".Busy"},    32'(Busy),    32'(busy));
        check({tag, ".Timeout"}, 32'(Timeout), 32'(tmo));
    endtask

    task automatic expect_en(input string tag, input int en, input int busy, input int tmo);
        check({tag, ".En"},      32'(En),      32'(en));
        check({tag, ".Busy"},    32'(Busy),    32'(busy));
        check({tag, ".Timeout"}, 32'(Timeout), 32'(tmo));
    endtask

    // Release the current grant with Done, then pass through GAP and IDLE.
    task automatic release_done(input string tag);
        Done = 1'b1;
        step();
        expect_en({tag, ".gap"}, 0, 1, 0);
        Done = 1'b0;
        step();
        expect_en({tag, ".idle"}, 0, 0, 0);
    endtask

    initial begin
        Resetn = 1'b0;
        R      = '0;
        Done   = 1'b0;

        // reset state
        step();
        step();
        expect_out("rst", 0, 0, 0, 0);
        check("rst.state", 32'(dbg_state), 32'(IDLE));

        // Round robin with every requester active: 0..7 then 0.
        // En is low for exactly two cycles between grants.
        Resetn = 1'b1;
        R      = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            step();
            expect_out($sformatf("rr%0d", g), g % 8, 1, 1, 0);
            check($sformatf("rr%0d.state", g), 32'(dbg_state), 32'(GRANT));
            release_done($sformatf("rr%0d", g));
        end
        // ptr is now 1

        // single request R[3]
        R = 8'b0001_0000;
        step();
        expect_out("single", 3, 1, 1, 0);
        Done = 1'b1;
        step();
        expect_out("single.gap", 3, 0, 1, 0);
        check("single.gap.state", 32'(dbg_state), 32'(GAP));
        Done = 1'b0;
        R    = 8'b0001_0100;   // R[3] and R[5]; ptr=4 must choose 5
        step();
        expect_en("single.idle", 0, 0, 0);
        step();
        expect_out("single.ptr4", 5, 1, 1, 0);
        release_done("single.ptr4");
        // ptr is now 6

        // pointer wrap: R[7] and R[2]
        R = 8'b0010_0001;
        step();
        expect_out("wrap.first", 7, 1, 1, 0);
        release_done("wrap.first");
        step();
        expect_out("wrap.second", 2, 1, 1, 0);
        release_done("wrap.second");
        // ptr is now 3

        // timeout: R[6] held, no Done, MAX_HOLD=4
        R = 8'b0000_0010;
        step();
        expect_out("tmo.c0", 6, 1, 1, 0);
        for (int c = 1; c < 4; c++) begin
            step();
            expect_out($sformatf("tmo.c%0d", c), 6, 1, 1, 0);
        end
        step();
        expect_out("tmo.release", 6, 0, 1, 1);
        R = 8'b0000_0011;      // R[6] and R[7]; ptr=7 must choose 7
        step();
        expect_en("tmo.idle", 0, 0, 0);
        step();
        expect_out("tmo.ptr7", 7, 1, 1, 0);
        release_done("tmo.ptr7");
        // ptr is now 0

        // withdrawal of R[1]
        R = 8'b0100_0000;
        step();
        expect_out("wd.grant", 1, 1, 1, 0);
        R = '0;
        step();
        expect_out("wd.release", 1, 0, 1, 0);
        step();
        expect_en("wd.idle", 0, 0, 0);
        // ptr is now 2

        // Done on the last allowed hold cycle is a normal release
        R = 8'b0000_1000;
        step();
        expect_out("dt.c0", 4, 1, 1, 0);
        for (int c = 1; c < 4; c++) begin
            step();
            expect_en($sformatf("dt.c%0d", c), 1, 1, 0);
        end
        Done = 1'b1;
        step();
        expect_out("dt.release", 4, 0, 1, 0);
        Done = 1'b0;
        R    = '0;
        step();
        expect_en("dt.idle", 0, 0, 0);
        // ptr is now 5

        // reset during a grant
        R = 8'b0000_0100;
        step();
        expect_out("mid.grant", 5, 1, 1, 0);
        Resetn = 1'b0;
        step();
        expect_out("mid.rst", 0, 0, 0, 0);
        check("mid.rst.state", 32'(dbg_state), 32'(IDLE));
        Resetn = 1'b1;
        R      = 8'b0000_0001;  // R[7] only
        step();
        expect_out("mid.after", 7, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_grant_encoder.md
Name: rr_grant_encoder

Overview:
- Round-robin arbiter directly upstream of the 3-to-8 enable decoder.
- Accepts 8 request lines and grants exactly one requester at a time.
- Drives the decoder's 3-bit select W and its enable En, so the decoder output Y is the one-hot grant vector.
- Enforces a one-cycle dead gap between grants and a bounded hold time.

Parameters:
- N, 8, number of requesters; fixed to match the decoder's output width.
- IDXW, 3, index width; log2(N).
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; legal range 2..255.
- CNTW, 8, width of the hold counter.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  synchronous active-low reset, sampled on the rising edge of Clock.
- R  in  [0:N-1]  request vector; R[i] requests grant i, with bit ordering matching decoder Y.
- Done  in  1  holder releases the grant; sampled only in GRANT.
- W  out  [IDXW-1:0]  encoded index of the current grantee, feeds decoder W.
- En  out  1  grant valid, feeds decoder En.
- Busy  out  1  high in GRANT and GAP.
- Timeout  out  1  one-cycle pulse when a grant is forcibly released.

Behaviour:
- Reset, on a rising edge with Resetn=0:
  - state=IDLE, W=0, En=0, Busy=0, Timeout=0.
  - Priority pointer ptr=0, hold counter=0.
  - Reset overrides everything, including mid-grant; En drops on that same edge.
- All outputs are registered. There is no combinational path from R or Done to any output.
- State IDLE:
  - If R has no bits set, stay in IDLE with En=0.
  - Otherwise select the first index k with R[k]=1, searching ptr, ptr+1, ... mod 8.
  - On the next edge: W=k, En=1, Busy=1, counter=0, go to GRANT.
  - Request-to-grant latency is 1 cycle.
- State GRANT. Each cycle, evaluate release conditions in this priority order:
  - (a) Done=1, or R[W]=0 (requester withdrew): normal release.
  - (b) counter==MAX_HOLD-1: forced release with Timeout=1 for that next cycle.
  - If neither applies, increment counter.
  - On release, at the next edge: En=0, ptr=W+1 mod 8 (wraps 7->0), go to GAP.
  - W holds its last value while En=0.
- State GAP:
  - Exactly one cycle with En=0 and Busy=1. Guarantees a decoder-output gap between grantees.
  - Then go to IDLE. Requests are re-evaluated in IDLE, so back-to-back grant spacing is 3 cycles: GRANT end -> GAP -> IDLE -> GRANT.
- Fairness:
  - The last grantee has the lowest priority on the next arbitration.
  - With all 8 requesting continuously, grant order is 0,1,...,7,0,...
- Timeout is asserted only in the cycle after a forced release and is 0 otherwise. Done and timeout in the same cycle count as a normal release (Timeout=0).
- Changes to R during GRANT for indices other than W are ignored until the next IDLE.
- Requester index 0 is never masked; ptr wrap uses modulo-8 arithmetic in IDXW bits.
- Invariant: En=1 only in GRANT, and at that time R[W] was 1 when the grant was issued.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, GRANT=2'd1, GAP=2'd2) and the constants N, IDXW.
- One sub-module is natural: rr_pick, a combinational rotating priority encoder.
  - Inputs: R[0:7], ptr[2:0].
  - Outputs: idx[2:0], any.
  - Instantiated once by rr_grant_encoder.

Test Plan:
- Reset mid-grant: grant index 5 active, Resetn=0 for one edge -> W=0, En=0, Busy=0 on that edge; after release with R=8'b0000_0001 (R[7] only) -> W=7, En=1 one cycle later.
- Single request: R[3]=1 only from IDLE -> next edge W=3, En=1; Done=1 -> next edge En=0 (GAP), then IDLE, ptr=4.
- Round robin: R=all ones, Done pulsed each grant -> W sequence 0,1,2,...,7,0, with En low for exactly 2 cycles between grants.
- Pointer wrap: grant 7 released with R[7] and R[2] still requesting -> next grant W=2 (search wraps past 0,1), not 7.
- Timeout: MAX_HOLD=4, R[6] held, Done=0 -> En high for exactly 4 cycles, then En=0 with Timeout=1 for one cycle, ptr=7.
- Withdrawal vs Done: R[1] drops while granted -> release with Timeout=0; Done and the timeout cycle coincide -> Timeout stays 0.
